uart_rx: RTL and testbench
==========================

# uart_rx

Oversampling UART receiver: the receive-side counterpart of the team's UART transmitter, sharing its frame format (start bit, DATA_WIDTH data bits LSB-first, optional even/odd parity, one stop bit, idle-high line). It samples the asynchronous serial line with a configurable oversampling ratio and takes a 3-sample majority vote at mid-bit. It delivers each good frame as a parallel word with a one-cycle valid strobe, and flags parity and stop-bit errors. It sits between the pad-side synchronizer and the system register file / FIFO.

## Interface
- DATA_WIDTH, 8, data bits per frame
- CLK  input  1  receiver oversampling clock, rising-edge
- RST  input  1  reset; one clock, asynchronous, active-low
- RX_IN  input  1  serial line, already 2-flop synchronized to CLK; idle = 1
- Prescale  input  6  oversampling ratio; legal values 8, 16, 32
- PAR_EN  input  1  1 = parity bit present in frame
- PAR_TYP  input  1  0 = even, 1 = odd (same encoding as transmitter)
- P_Data  output  DATA_WIDTH  received word; holds last good value
- Data_Valid  output  1  one-cycle pulse: P_Data updated with a good frame
- Par_Err  output  1  one-cycle pulse: parity mismatch
- Stop_Err  output  1  one-cycle pulse: stop bit sampled 0

## Operation
- Reset: FSM = IDLE, counters 0, P_Data = 0, Data_Valid = Par_Err = Stop_Err = 0.
- Counters:
  - edge_cnt counts 0..Prescale-1 within a bit; bit_cnt indexes the bit within the frame.
  - edge_cnt wraps to 0 at Prescale-1 and increments bit_cnt.
- Sampling:
  - Samples are taken at edge_cnt = Prescale/2-1, Prescale/2 and Prescale/2+1.
  - bit value = majority(3 samples); the result is valid from edge_cnt = Prescale/2+2.
- FSM states:
  - IDLE: waits for RX_IN = 0, then → START. Counters clear; PAR_EN, PAR_TYP and Prescale are latched here and held for the frame.
  - START: at the vote, sampled 1 is a glitch → IDLE with no flags; sampled 0 continues. At edge_cnt wrap → DATA.
  - DATA: the voted bit is shifted into the shift register LSB-first. After DATA_WIDTH bits → PARITY if latched PAR_EN, else → STOP.
  - PARITY: the voted bit is compared with the computed parity. Expected bit = XOR(data) for even, ~XOR(data) for odd. A mismatch sets a pending parity-error flag. At wrap → STOP.
  - STOP: at the vote (edge_cnt = Prescale/2+2), outputs are resolved on one edge and the FSM → IDLE in the same cycle. This mid-stop-bit resync lets a back-to-back frame's start edge be caught.
- Output resolution on that edge:
  - stop = 0 → Stop_Err = 1.
  - pending parity error → Par_Err = 1.
  - neither → P_Data ← shift register, Data_Valid = 1.
  - Par_Err and Stop_Err may pulse together; Data_Valid is never asserted with either.
- Prescale changes mid-frame are ignored until the next IDLE.
- Async RST mid-frame aborts the frame with no pulses. Afterwards the receiver resynchronizes on the next falling edge after the line has been seen high.

## Timing
- Start detect: FSM is in START one cycle after the first CLK edge that sees RX_IN = 0.
- Bit centre: the vote for bit k (k = 0 is the start bit) resolves Prescale·k + Prescale/2+2 cycles after start detect.
- Frame latency: the output pulse comes Prescale·(DATA_WIDTH+1+PAR_EN) + Prescale/2+3 cycles after the falling edge is registered.
- All flag outputs are single-cycle pulses with no handshake; the consumer must accept them immediately.
- P_Data is stable from the Data_Valid edge until the next good frame.
- Tolerates ±(Prescale/2-2)/Prescale bit-period phase error accumulated over the frame.

## Structure
- Shared UART package:
  - FSM state encoding (IDLE, START, DATA, PARITY, STOP).
  - Parity-type constants (EVEN = 0, ODD = 1).
  - Idle/start/stop line levels, reused with the transmitter.
- Sub-module edge_bit_counter: edge_cnt/bit_cnt, with enable and Prescale inputs.
- Majority sampling, the shift register and the parity check stay in the top level. Expected size is about 250 lines.

## Test plan
- Prescale = 8, PAR_EN = 0, frame 0xA5 → Data_Valid pulse, P_Data = 0xA5, no error flags, pulse at 8·9 + 7 cycles after the falling edge.
- Prescale = 16, PAR_EN = 1, PAR_TYP = 0, byte 0x3C with parity bit 0 → valid 0x3C. Same frame with parity bit 1 → Par_Err pulse, P_Data unchanged.
- Prescale = 32, PAR_TYP = 1, byte 0x01 with stop bit forced 0 → Stop_Err pulse only, no Data_Valid.
- RX_IN low for 3 cycles at Prescale = 16 (glitch) → FSM returns to IDLE, no pulses. A following real frame 0x5A is received correctly.
- Single-cycle inverted spikes at one of the three sample points in every bit of 0xFF/0x00 frames → correct data via majority vote.
- Two back-to-back frames (0x12, 0x34) with no idle gap, plus RST asserted mid-second-frame → 0x12 valid. The aborted frame produces no pulse; outputs are 0 after reset.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared UART definitions: receiver FSM states, parity/line levels and the
// per-frame configuration snapshot taken while the receiver is idle.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_e;

  localparam logic PAR_EVEN  = 1'b0;
  localparam logic PAR_ODD   = 1'b1;
  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  localparam int PRESCALE_W = 6;

  typedef struct packed {
    logic [PRESCALE_W-1:0] prescale;
    logic                  par_en;
    logic                  par_typ;
  } rx_cfg_t;

  function automatic logic maj3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

endpackage

// File: rtl/uart_rx_edge_bit_counter.sv
// Oversampling position within a frame: edge_cnt walks 0..prescale-1 per bit,
// bit_cnt advances on each wrap. Both clear whenever the counter is disabled.
module uart_rx_edge_bit_counter
  import uart_rx_pkg::*;
#(
  parameter int BIT_W = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  en,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic [PRESCALE_W-1:0] edge_cnt,
  output logic [BIT_W-1:0]      bit_cnt,
  output logic                  wrap
);

  assign wrap = (edge_cnt == prescale - PRESCALE_W'(1));

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else if (!en) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else if (wrap) begin
      edge_cnt <= '0;
      bit_cnt  <= bit_cnt + 1'b1;
    end else begin
      edge_cnt <= edge_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: 3-sample mid-bit majority vote, LSB-first
// shift-in, optional parity, and single-cycle valid/error pulses.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [PRESCALE_W-1:0] Prescale,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [DATA_WIDTH-1:0] P_Data,
  output logic                  Data_Valid,
  output logic                  Par_Err,
  output logic                  Stop_Err
);

  localparam int BIT_W = $clog2(DATA_WIDTH + 3);

  rx_state_e             state;
  rx_cfg_t               cfg;
  logic [PRESCALE_W-1:0] edge_cnt;
  logic [BIT_W-1:0]      bit_cnt;
  logic                  wrap;
  logic [PRESCALE_W-1:0] half;
  logic [2:0]            smp;
  logic                  voted;
  logic                  at_vote;
  logic                  rx_prev;
  logic                  par_pend;
  logic                  par_exp;
  logic [DATA_WIDTH-1:0] shreg;

  uart_rx_edge_bit_counter #(.BIT_W(BIT_W)) u_cnt (
    .CLK      (CLK),
    .RST      (RST),
    .en       (state != ST_IDLE),
    .prescale (cfg.prescale),
    .edge_cnt (edge_cnt),
    .bit_cnt  (bit_cnt),
    .wrap     (wrap)
  );

  assign half    = {1'b0, cfg.prescale[PRESCALE_W-1:1]};
  assign voted   = maj3(smp);
  assign at_vote = (edge_cnt == half + PRESCALE_W'(2));
  assign par_exp = (^shreg) ^ (cfg.par_typ == PAR_ODD);

  // Three consecutive samples straddling the bit centre; the vote uses them
  // on the following edge.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      smp <= '0;
    end else if (state != ST_IDLE) begin
      if (edge_cnt == half - PRESCALE_W'(1)) smp[0] <= RX_IN;
      if (edge_cnt == half)                  smp[1] <= RX_IN;
      if (edge_cnt == half + PRESCALE_W'(1)) smp[2] <= RX_IN;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state      <= ST_IDLE;
      cfg        <= '0;
      rx_prev    <= 1'b0;
      par_pend   <= 1'b0;
      shreg      <= '0;
      P_Data     <= '0;
      Data_Valid <= 1'b0;
      Par_Err    <= 1'b0;
      Stop_Err   <= 1'b0;
    end else begin
      rx_prev    <= RX_IN;
      Data_Valid <= 1'b0;
      Par_Err    <= 1'b0;
      Stop_Err   <= 1'b0;
      case (state)
        ST_IDLE: begin
          cfg      <= '{prescale: Prescale, par_en: PAR_EN, par_typ: PAR_TYP};
          par_pend <= 1'b0;
          // A start needs a genuine high-to-low edge, so a reset in the
          // middle of a low bit cannot launch a bogus frame.
          if (rx_prev == LINE_IDLE && RX_IN == START_BIT) state <= ST_START;
        end
        ST_START: begin
          if (at_vote && voted != START_BIT) state <= ST_IDLE;
          else if (wrap)                     state <= ST_DATA;
        end
        ST_DATA: begin
          if (at_vote) shreg <= {voted, shreg[DATA_WIDTH-1:1]};
          if (wrap && bit_cnt == BIT_W'(DATA_WIDTH))
            state <= cfg.par_en ? ST_PARITY : ST_STOP;
        end
        ST_PARITY: begin
          if (at_vote && voted != par_exp) par_pend <= 1'b1;
          if (wrap) state <= ST_STOP;
        end
        ST_STOP: begin
          // Resolve at mid-stop-bit so a back-to-back start edge is not missed.
          if (at_vote) begin
            Stop_Err <= (voted != STOP_BIT);
            Par_Err  <= par_pend;
            if (voted == STOP_BIT && !par_pend) begin
              P_Data     <= shreg;
              Data_Valid <= 1'b1;
            end
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: frames are built bit by bit, outcomes and
// pulse times predicted from frame contents and compared against a pulse log.
module tb_uart_rx;
  localparam int DW = 8;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          RX_IN = 1'b1;
  logic [5:0]    Prescale = 6'd16;
  logic          PAR_EN = 1'b0;
  logic          PAR_TYP = 1'b0;
  logic [DW-1:0] P_Data;
  logic          Data_Valid, Par_Err, Stop_Err;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [DW-1:0] last_good = '0;

  typedef struct packed {
    int          cyc;
    logic        dv;
    logic        pe;
    logic        se;
    logic [DW-1:0] data;
  } rec_t;

  rec_t q[$];

  uart_rx #(.DATA_WIDTH(DW)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .RX_IN      (RX_IN),
    .Prescale   (Prescale),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .P_Data     (P_Data),
    .Data_Valid (Data_Valid),
    .Par_Err    (Par_Err),
    .Stop_Err   (Stop_Err)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // Pulse log, sampled mid-cycle.
  always @(negedge CLK)
    if (Data_Valid || Par_Err || Stop_Err)
      q.push_back('{cyc: cyc, dv: Data_Valid, pe: Par_Err, se: Stop_Err, data: P_Data});

  function automatic string fmt(rec_t r);
    return $sformatf("cyc=%0d dv=%b pe=%b se=%b data=%h", r.cyc, r.dv, r.pe, r.se, r.data);
  endfunction

  function automatic logic [5:0] pick_p();
    case ($urandom_range(2, 0))
      0:       return 6'd8;
      1:       return 6'd16;
      default: return 6'd32;
    endcase
  endfunction

  // Drives a frame starting at the current negedge; t0 is the cycle count at
  // the start-bit drive. lim truncates the frame (line left at last bit).
  task automatic send_frame(input int p, input logic [DW-1:0] d, input bit pe, input bit pt,
                            input bit flip, input bit stop_v, input bit spikes,
                            input int lim, input bit scramble, output int t0);
    logic bits [0:DW+2];
    int   n;
    int   spk;
    bits[0] = 1'b0;
    for (int i = 0; i < DW; i++) bits[i+1] = d[i];
    n = DW + 1;
    if (pe) begin
      bits[n] = (^d) ^ pt ^ flip;
      n++;
    end
    bits[n] = stop_v;
    n++;
    Prescale = 6'(p);
    PAR_EN   = pe;
    PAR_TYP  = pt;
    t0 = cyc;
    for (int k = 0; k < n && k < lim; k++) begin
      spk = p / 2 + int'($urandom_range(2, 0));
      for (int j = 0; j < p; j++) begin
        RX_IN = (spikes && j == spk) ? ~bits[k] : bits[k];
        if (scramble && k == 1 && j == 0) begin
          Prescale = pick_p();
          PAR_EN   = 1'($urandom);
          PAR_TYP  = 1'($urandom);
        end
        @(negedge CLK);
      end
    end
    if (lim >= n) RX_IN = 1'b1;
  endtask

  // Reference: outcome follows directly from frame content; the pulse lands
  // half a bit plus pipeline delay into the stop bit.
  task automatic model_frame(input int p, input logic [DW-1:0] d, input bit pe, input bit flip,
                             input bit stop_v, input int t0, output rec_t e);
    e.cyc = t0 + 1 + p * (DW + 1 + (pe ? 1 : 0)) + p / 2 + 3;
    e.se  = !stop_v;
    e.pe  = pe && flip;
    e.dv  = stop_v && !(pe && flip);
    if (e.dv) last_good = d;
    e.data = last_good;
  endtask

  task automatic get_rec(output rec_t r);
    r = '{cyc: -1, dv: 1'b0, pe: 1'b0, se: 1'b0, data: '0};
    for (int i = 0; i < 40 && q.size() == 0; i++) @(negedge CLK);
    if (q.size() != 0) r = q.pop_front();
  endtask

  task automatic idle(input int n);
    RX_IN = 1'b1;
    repeat (n) @(negedge CLK);
  endtask

  task automatic test_reset();
    RST = 1'b0;
    RX_IN = 1'b1;
    repeat (3) @(negedge CLK);
    total++;
    if ({P_Data, Data_Valid, Par_Err, Stop_Err} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got %h/%b%b%b exp 00/000", P_Data, Data_Valid, Par_Err, Stop_Err);
    end
    RST = 1'b1;
    last_good = '0;
    idle(4);
  endtask

  task automatic test_basic();
    int t0; rec_t e, r;
    send_frame(8, 8'hA5, 0, 0, 0, 1, 0, 99, 0, t0);
    model_frame(8, 8'hA5, 0, 0, 1, t0, e);
    get_rec(r);
    total++;
    if (r !== e) begin bad++; $display("FAIL basic_a5: got %s exp %s", fmt(r), fmt(e)); end
    idle(5);
  endtask

  task automatic test_parity();
    int t0; rec_t e, r;
    for (int f = 0; f < 2; f++) begin
      send_frame(16, 8'h3C, 1, 0, f[0], 1, 0, 99, 0, t0);
      model_frame(16, 8'h3C, 1, f[0], 1, t0, e);
      get_rec(r);
      total++;
      if (r !== e) begin bad++; $display("FAIL parity_%0d: got %s exp %s", f, fmt(r), fmt(e)); end
      idle(7);
    end
  endtask

  task automatic test_stop_err();
    int t0; rec_t e, r;
    send_frame(32, 8'h01, 1, 1, 0, 0, 0, 99, 0, t0);
    model_frame(32, 8'h01, 1, 0, 0, t0, e);
    get_rec(r);
    total++;
    if (r !== e) begin bad++; $display("FAIL stop_err: got %s exp %s", fmt(r), fmt(e)); end
    idle(10);
  endtask

  task automatic test_glitch();
    int t0; rec_t e, r;
    Prescale = 6'd16;
    PAR_EN   = 1'b0;
    RX_IN    = 1'b0;
    repeat (3) @(negedge CLK);
    idle(48);
    total++;
    if (q.size() !== 0) begin bad++; $display("FAIL glitch_quiet: got %0d pulses exp 0", q.size()); end
    q.delete();
    send_frame(16, 8'h5A, 0, 0, 0, 1, 0, 99, 0, t0);
    model_frame(16, 8'h5A, 0, 0, 1, t0, e);
    get_rec(r);
    total++;
    if (r !== e) begin bad++; $display("FAIL glitch_follow: got %s exp %s", fmt(r), fmt(e)); end
    idle(6);
  endtask

  task automatic test_spikes();
    int t0, p; bit pe; logic [DW-1:0] d; rec_t e, r;
    for (int f = 0; f < 4; f++) begin
      p  = int'(pick_p());
      pe = 1'($urandom);
      d  = f[0] ? 8'hFF : 8'h00;
      send_frame(p, d, pe, 1'($urandom), 0, 1, 1, 99, 0, t0);
      model_frame(p, d, pe, 0, 1, t0, e);
      get_rec(r);
      total++;
      if (r !== e) begin bad++; $display("FAIL spikes_%0d p=%0d: got %s exp %s", f, p, fmt(r), fmt(e)); end
      idle(3);
    end
  endtask

  task automatic test_random();
    int t0, p; bit pe, pt, flip, stop_v; logic [DW-1:0] d; rec_t e, r;
    for (int f = 0; f < 12; f++) begin
      p      = int'(pick_p());
      d      = DW'($urandom);
      pe     = 1'($urandom);
      pt     = 1'($urandom);
      flip   = ($urandom_range(3, 0) == 0);
      stop_v = ($urandom_range(4, 0) != 0);
      send_frame(p, d, pe, pt, flip, stop_v, 0, 99, 1, t0);
      model_frame(p, d, pe, flip, stop_v, t0, e);
      get_rec(r);
      total++;
      if (r !== e) begin bad++; $display("FAIL random_%0d p=%0d pe=%0b: got %s exp %s", f, p, pe, fmt(r), fmt(e)); end
      idle(int'($urandom_range(p, 1)));
    end
  endtask

  task automatic test_back_to_back();
    int t0a, t0b; rec_t e, r;
    send_frame(16, 8'h12, 0, 0, 0, 1, 0, 99, 0, t0a);
    model_frame(16, 8'h12, 0, 0, 1, t0a, e);
    send_frame(16, 8'h34, 0, 0, 0, 1, 0, 5, 0, t0b);
    RST   = 1'b0;
    RX_IN = 1'b0;
    repeat (2) @(negedge CLK);
    get_rec(r);
    total++;
    if (r !== e) begin bad++; $display("FAIL b2b_first: got %s exp %s", fmt(r), fmt(e)); end
    total++;
    if ({P_Data, Data_Valid, Par_Err, Stop_Err} !== '0) begin
      bad++;
      $display("FAIL b2b_reset_outputs: got %h/%b%b%b exp 00/000", P_Data, Data_Valid, Par_Err, Stop_Err);
    end
    RST = 1'b1;
    last_good = '0;
    repeat (32) @(negedge CLK);
    idle(64);
    total++;
    if (q.size() !== 0) begin bad++; $display("FAIL b2b_aborted_quiet: got %0d pulses exp 0", q.size()); end
    q.delete();
    total++;
    if (P_Data !== '0) begin bad++; $display("FAIL b2b_pdata_after_reset: got %h exp 00", P_Data); end
    send_frame(8, 8'hC3, 1, 1, 0, 1, 0, 99, 0, t0b);
    model_frame(8, 8'hC3, 1, 0, 1, t0b, e);
    get_rec(r);
    total++;
    if (r !== e) begin bad++; $display("FAIL b2b_recover: got %s exp %s", fmt(r), fmt(e)); end
    idle(6);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_stop_err();
    test_glitch();
    test_spikes();
    test_random();
    test_back_to_back();
    total++;
    if (q.size() !== 0) begin bad++; $display("FAIL stray_pulses: got %0d exp 0", q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
